tone_period_detector: RTL and testbench

Receive-side counterpart to the tone generator. It accepts a square-wave audio tone and measures the number of clk cycles between consecutive toggles, expressed in the same units as the generator's tone_switch_period. It reports each measurement with a one-cycle valid strobe and flags whether a tone is present. It is used for loopback self-test of the audio path and for pitch detection on an external square-wave input.

---
 rtl/tone_period_detector.sv | 122 ++++++++++++
 tb/tb_tone_period_detector.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/tone_period_detector.sv
// Measures clk cycles between toggles of an asynchronous square wave and reports
// each accepted interval, tone presence and a saturating glitch count.
//
// state      | meaning
// IDLE       | disabled, counter held at 0, outputs cleared
// WAIT_FIRST | waiting for a reference toggle, no reports
// MEASURE    | timing intervals between toggles and reporting them
module tone_period_detector #(
  parameter int PERIOD_WIDTH    = 24,
  parameter int MIN_HALF_PERIOD = 16,
  parameter int TIMEOUT_CLOCKS  = 12500000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    square_wave_in,
  output logic [PERIOD_WIDTH-1:0] tone_switch_period,
  output logic                    period_valid,
  output logic                    tone_present,
  output logic [7:0]              glitch_count
);

  localparam logic [PERIOD_WIDTH-1:0] TIMEOUT  = PERIOD_WIDTH'(TIMEOUT_CLOCKS);
  localparam logic [PERIOD_WIDTH-1:0] MIN_HALF = PERIOD_WIDTH'(MIN_HALF_PERIOD);
  localparam logic [PERIOD_WIDTH-1:0] ONE      = PERIOD_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FIRST = 2'd1,
    MEASURE    = 2'd2
  } state_t;

  state_t                  state, state_nxt;
  logic                    sync_meta, sync_out, sync_prev;
  logic [PERIOD_WIDTH-1:0] counter, counter_nxt;
  logic [PERIOD_WIDTH-1:0] period_nxt;
  logic                    valid_nxt, present_nxt;
  logic [7:0]              glitch_nxt;
  logic                    toggle, timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta          <= 1'b0;
      sync_out           <= 1'b0;
      sync_prev          <= 1'b0;
      state              <= IDLE;
      counter            <= '0;
      tone_switch_period <= '0;
      period_valid       <= 1'b0;
      tone_present       <= 1'b0;
      glitch_count       <= 8'd0;
    end else begin
      sync_meta          <= square_wave_in;
      sync_out           <= sync_meta;
      sync_prev          <= sync_out;
      state              <= state_nxt;
      counter            <= counter_nxt;
      tone_switch_period <= period_nxt;
      period_valid       <= valid_nxt;
      tone_present       <= present_nxt;
      glitch_count       <= glitch_nxt;
    end
  end

  always_comb begin
    toggle  = sync_out ^ sync_prev;
    timeout = (counter >= TIMEOUT);

    state_nxt   = state;
    counter_nxt = timeout ? counter : counter + ONE;
    period_nxt  = tone_switch_period;
    valid_nxt   = 1'b0;
    present_nxt = tone_present;
    glitch_nxt  = glitch_count;

    if (!enable) begin
      state_nxt   = IDLE;
      counter_nxt = '0;
      period_nxt  = '0;
      present_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          counter_nxt = '0;
          state_nxt   = WAIT_FIRST;
        end
        WAIT_FIRST: begin
          if (toggle) begin
            counter_nxt = ONE;
            state_nxt   = MEASURE;
          end else if (timeout) begin
            present_nxt = 1'b0;
            period_nxt  = '0;
          end
        end
        MEASURE: begin
          // a toggle landing on the timeout cycle still counts as a measurement
          if (toggle) begin
            counter_nxt = ONE;
            if (counter >= MIN_HALF) begin
              period_nxt  = counter;
              valid_nxt   = 1'b1;
              present_nxt = 1'b1;
            end else begin
              if (glitch_count != 8'hFF) glitch_nxt = glitch_count + 8'd1;
              state_nxt = WAIT_FIRST;
            end
          end else if (timeout) begin
            present_nxt = 1'b0;
            period_nxt  = '0;
            state_nxt   = WAIT_FIRST;
          end
        end
        default: begin
          state_nxt   = IDLE;
          counter_nxt = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tone_period_detector.sv
// Randomized bench for tone_period_detector; a timestamp-based reference model
// predicts every output after every clock edge.
module tb_tone_period_detector;

  localparam int PW   = 24;
  localparam int MINH = 16;
  localparam int TMO  = 2000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          square_wave_in = 1'b0;
  logic [PW-1:0] tone_switch_period;
  logic          period_valid;
  logic          tone_present;
  logic [7:0]    glitch_count;

  tone_period_detector #(
    .PERIOD_WIDTH(PW), .MIN_HALF_PERIOD(MINH), .TIMEOUT_CLOCKS(TMO)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .square_wave_in(square_wave_in),
    .tone_switch_period(tone_switch_period), .period_valid(period_valid),
    .tone_present(tone_present), .glitch_count(glitch_count)
  );

  always #4 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: pin history per edge plus the time of the last reference toggle.
  bit hist [0:131071];
  int edge_n = 3;
  int mode   = 0;        // 0 disabled, 1 waiting for reference toggle, 2 measuring
  int ref_t  = 0;
  int m_period = 0;
  bit m_valid  = 0;
  bit m_present = 0;
  int m_glitch = 0;

  function automatic int elapsed(input int now);
    int el;
    el = now - ref_t;
    if (el > TMO) el = TMO;
    return el;
  endfunction

  task automatic model_edge();
    bit det;
    int el;
    // input change becomes visible to the measurement logic two edges after it is sampled
    det = hist[edge_n-2] != hist[edge_n-3];
    hist[edge_n] = square_wave_in;
    m_valid = 0;
    if (rst) begin
      hist[edge_n] = 0; hist[edge_n-1] = 0; hist[edge_n-2] = 0;
      mode = 0; m_period = 0; m_present = 0; m_glitch = 0;
    end else if (!enable) begin
      mode = 0; m_period = 0; m_present = 0;
    end else begin
      el = elapsed(edge_n);
      if (mode == 0) begin
        mode  = 1;
        ref_t = edge_n + 1;
      end else if (mode == 1) begin
        if (det) begin
          mode = 2; ref_t = edge_n;
        end else if (el >= TMO) begin
          m_present = 0; m_period = 0;
        end
      end else begin
        if (det) begin
          if (el >= MINH) begin
            m_period = el; m_valid = 1; m_present = 1;
          end else begin
            if (m_glitch < 255) m_glitch++;
            mode = 1;
          end
          ref_t = edge_n;
        end else if (el >= TMO) begin
          m_present = 0; m_period = 0; mode = 1;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    edge_n++;
    model_edge();
    #1;
    check("period_valid", 32'(period_valid), 32'(m_valid));
    check("tone_switch_period", 32'(tone_switch_period), 32'(m_period));
    check("tone_present", 32'(tone_present), 32'(m_present));
    check("glitch_count", 32'(glitch_count), 32'(m_glitch));
  endtask

  task automatic toggle_run(input int half, input int n);
    repeat (n) begin
      square_wave_in = ~square_wave_in;
      repeat (half) tick();
    end
  endtask

  int half;

  initial begin
    hist[0] = 0; hist[1] = 0; hist[2] = 0;
    rst = 1; enable = 0; square_wave_in = 0;
    repeat (4) tick();
    rst = 0; enable = 1;

    toggle_run(500, 8);
    toggle_run(420, 8);

    // short pulse in the middle of a half period
    square_wave_in = ~square_wave_in; repeat (250) tick();
    square_wave_in = ~square_wave_in; repeat (5) tick();
    square_wave_in = ~square_wave_in; repeat (245) tick();
    toggle_run(500, 4);

    // glitch threshold and timeout boundaries
    toggle_run(MINH, 3);
    toggle_run(MINH - 1, 3);
    toggle_run(500, 3);
    toggle_run(TMO, 3);
    toggle_run(TMO + 1, 2);
    toggle_run(500, 3);

    repeat (TMO + 300) tick();

    toggle_run(500, 4);
    square_wave_in = ~square_wave_in; repeat (200) tick();
    enable = 0; repeat (1000) tick();
    enable = 1;
    toggle_run(500, 5);

    toggle_run(500, 4);
    square_wave_in = ~square_wave_in; repeat (200) tick();
    rst = 1; tick(); rst = 0;
    repeat (300) tick();
    toggle_run(500, 4);

    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 4) == 0) half = $urandom_range(1, 20);
      else half = $urandom_range(100, 1200);
      if ($urandom_range(0, 9) == 0) begin
        enable = 0;
        repeat ($urandom_range(5, 50)) tick();
        enable = 1;
      end
      toggle_run(half, 1);
    end

    // rapid toggling drives the glitch counter into saturation
    toggle_run(2, 600);
    toggle_run(500, 4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
